// File: rtl/dcache_pkg.sv
// Shared types, widths and address helpers for the direct-mapped data-cache controller.
package dcache_pkg;

    localparam int TAG_W      = 5;
    localparam int IDX_W      = 8;
    localparam int OFF_W      = 2;
    localparam int LINE_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WB    = 3'd1,
        ALLOC = 3'd2,
        RETRY = 3'd3
    } state_t;

    // Byte address split as tag | index | word offset | byte select.
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [OFF_W-1:0] off;
        logic             odd;
    } addr_t;

    function automatic addr_t split_addr(input logic [15:0] a);
        return addr_t'(a);
    endfunction

    function automatic logic [15:0] word_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [OFF_W-1:0] off);
        return {tag, idx, off, 1'b0};
    endfunction

endpackage

// File: rtl/dcache_fill_tracker.sv
// Follows each accepted line-fill read through the MEM_LAT-cycle memory pipe and flags
// the cycle its word returns, together with the word offset to install it at.
module dcache_fill_tracker
    import dcache_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [OFF_W-1:0] issue_off,
    output logic             ret_valid,
    output logic [OFF_W-1:0] ret_off
);

    logic             vld_q [MEM_LAT];
    logic [OFF_W-1:0] off_q [MEM_LAT];

    // NOTE: this small pipe is reset so an aborted fill cannot leave a phantom return behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                vld_q[i] <= 1'b0;
                off_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= issue;
            off_q[0] <= issue_off;
            for (int i = 1; i < MEM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                off_q[i] <= off_q[i-1];
            end
        end
    end

    assign ret_valid = vld_q[MEM_LAT-1];
    assign ret_off   = off_q[MEM_LAT-1];

endmodule

// File: rtl/dmem_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data-cache controller in front of banked memory.
// Define DCACHE_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module dmem_cache_ctrl
    import dcache_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      Addr,
    input  logic [15:0]      DataIn,
    input  logic             Rd,
    input  logic             Wr,
    output logic [15:0]      DataOut,
    output logic             Done,
    output logic             Stall,
    output logic             CacheHit,
    output logic             err,
    output logic             c_en,
    output logic             c_cmp,
    output logic             c_wr,
    output logic [IDX_W-1:0] c_index,
    output logic [OFF_W-1:0] c_off,
    output logic [TAG_W-1:0] c_tag,
    output logic [15:0]      c_wdata,
    output logic             c_valid_in,
    input  logic             c_hit,
    input  logic             c_dirty,
    input  logic             c_valid,
    input  logic [TAG_W-1:0] c_rtag,
    input  logic [15:0]      c_rdata,
    output logic [15:0]      m_addr,
    output logic [15:0]      m_wdata,
    output logic             m_rd,
    output logic             m_wr,
    input  logic [15:0]      m_rdata,
    input  logic             m_stall
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0]      hit_cnt,
    output logic [15:0]      miss_cnt
`endif
);

    state_t           state;
    logic [2:0]       cnt;
    logic [1:0]       rcv_cnt;
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;
    logic [OFF_W-1:0] miss_off;
    logic [15:0]      miss_data;
    logic             miss_wr;

    addr_t            cur;
    logic             req_bad;
    logic             req_ok;
    logic             issue_go;
    logic             ret_valid;
    logic [OFF_W-1:0] ret_off;

    assign cur      = split_addr(Addr);
    assign req_bad  = (Rd & Wr) | ((Rd | Wr) & cur.odd);
    assign req_ok   = (Rd ^ Wr) & ~cur.odd;
    assign issue_go = m_rd & ~m_stall;

    dcache_fill_tracker #(.MEM_LAT(MEM_LAT)) u_fill (
        .clk      (clk),
        .rst      (rst),
        .issue    (issue_go),
        .issue_off(cnt[OFF_W-1:0]),
        .ret_valid(ret_valid),
        .ret_off  (ret_off)
    );

    // NOTE: state updates use <= so every branch sees the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rcv_cnt   <= '0;
            miss_tag  <= '0;
            miss_idx  <= '0;
            miss_off  <= '0;
            miss_data <= '0;
            miss_wr   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_ok && !c_hit) begin
                    miss_tag  <= cur.tag;
                    miss_idx  <= cur.idx;
                    miss_off  <= cur.off;
                    miss_data <= DataIn;
                    miss_wr   <= Wr;
                    cnt       <= '0;
                    rcv_cnt   <= '0;
                    state     <= (c_valid && c_dirty) ? WB : ALLOC;
                end
                WB: if (!m_stall) begin
                    if (cnt == 3'(LINE_WORDS - 1)) begin
                        cnt   <= '0;
                        state <= ALLOC;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ALLOC: begin
                    if (issue_go) cnt <= cnt + 3'd1;
                    if (ret_valid) begin
                        rcv_cnt <= rcv_cnt + 2'd1;
                        if (rcv_cnt == 2'(LINE_WORDS - 1)) state <= RETRY;
                    end
                end
                RETRY:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array port: compare lookups in IDLE/RETRY, plain reads in WB, line installs in ALLOC.
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        c_en       = 1'b0;
        c_cmp      = 1'b0;
        c_wr       = 1'b0;
        c_index    = '0;
        c_off      = '0;
        c_tag      = '0;
        c_wdata    = '0;
        c_valid_in = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: if (req_ok) begin
                    c_en       = 1'b1;
                    c_cmp      = 1'b1;
                    c_wr       = Wr;
                    c_index    = cur.idx;
                    c_off      = cur.off;
                    c_tag      = cur.tag;
                    c_wdata    = DataIn;
                    c_valid_in = Wr;
                end
                WB: begin
                    c_en    = 1'b1;
                    c_index = miss_idx;
                    c_off   = cnt[OFF_W-1:0];
                    c_tag   = miss_tag;
                end
                ALLOC: if (ret_valid) begin
                    c_en       = 1'b1;
                    c_wr       = 1'b1;
                    c_valid_in = 1'b1;
                    c_index    = miss_idx;
                    c_off      = ret_off;
                    c_tag      = miss_tag;
                    c_wdata    = m_rdata;
                end
                RETRY: begin
                    c_en       = 1'b1;
                    c_cmp      = 1'b1;
                    c_wr       = miss_wr;
                    c_index    = miss_idx;
                    c_off      = miss_off;
                    c_tag      = miss_tag;
                    c_wdata    = miss_data;
                    c_valid_in = miss_wr;
                end
                default: ;
            endcase
        end
    end

    // Memory port: victim write-back uses the stored tag, fills use the requested tag.
    always_comb begin
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (!rst) begin
            case (state)
                WB: begin
                    m_wr    = 1'b1;
                    m_addr  = word_addr(c_rtag, miss_idx, cnt[OFF_W-1:0]);
                    m_wdata = c_rdata;
                end
                ALLOC: if (!cnt[2]) begin
                    m_rd   = 1'b1;
                    m_addr = word_addr(miss_tag, miss_idx, cnt[OFF_W-1:0]);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Done     = 1'b0;
        Stall    = 1'b0;
        CacheHit = 1'b0;
        err      = 1'b0;
        DataOut  = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req_bad) begin
                        err = 1'b1;
                    end else if (req_ok) begin
                        if (c_hit) begin
                            Done     = 1'b1;
                            CacheHit = 1'b1;
                            DataOut  = Wr ? '0 : c_rdata;
                        end else begin
                            Stall = 1'b1;
                        end
                    end
                end
                WB, ALLOC: Stall = 1'b1;
                RETRY: begin
                    if (c_hit) begin
                        Done    = 1'b1;
                        DataOut = miss_wr ? '0 : c_rdata;
                    end else begin
                        err = 1'b1;
                    end
                end
                default: err = 1'b1;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (Done) begin
            if (CacheHit) begin
                if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else if (miss_cnt != 16'hFFFF) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_cache_ctrl.sv
// Self-checking bench: tag/data array and MEM_LAT=2 memory environment, line-level reference model.
module tb_dmem_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Addr, DataIn;
    logic        Rd, Wr;
    logic [15:0] DataOut;
    logic        Done, Stall, CacheHit, err;
    logic        c_en, c_cmp, c_wr;
    logic [7:0]  c_index;
    logic [1:0]  c_off;
    logic [4:0]  c_tag;
    logic [15:0] c_wdata;
    logic        c_valid_in;
    logic        c_hit, c_dirty, c_valid;
    logic [4:0]  c_rtag;
    logic [15:0] c_rdata;
    logic [15:0] m_addr, m_wdata;
    logic        m_rd, m_wr;
    logic [15:0] m_rdata;
    logic        m_stall;
`ifdef DCACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    dmem_cache_ctrl dut (
        .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
        .c_en(c_en), .c_cmp(c_cmp), .c_wr(c_wr), .c_index(c_index), .c_off(c_off),
        .c_tag(c_tag), .c_wdata(c_wdata), .c_valid_in(c_valid_in),
        .c_hit(c_hit), .c_dirty(c_dirty), .c_valid(c_valid), .c_rtag(c_rtag), .c_rdata(c_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rd(m_rd), .m_wr(m_wr),
        .m_rdata(m_rdata), .m_stall(m_stall)
`ifdef DCACHE_STATS_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    // ---------------- environment: tag/data array ----------------
    logic        arr_v    [256];
    logic        arr_d    [256];
    logic [4:0]  arr_t    [256];
    logic [15:0] arr_data [256][4];

    assign c_valid = arr_v[c_index];
    assign c_dirty = arr_d[c_index];
    assign c_rtag  = arr_t[c_index];
    assign c_rdata = arr_data[c_index][c_off];
    assign c_hit   = arr_v[c_index] && (arr_t[c_index] == c_tag);

    always @(posedge clk) begin
        if (c_en && c_wr) begin
            if (c_cmp) begin
                if (c_hit) begin
                    arr_data[c_index][c_off] <= c_wdata;
                    arr_d[c_index]           <= 1'b1;
                end
            end else begin
                arr_data[c_index][c_off] <= c_wdata;
                arr_t[c_index]           <= c_tag;
                arr_v[c_index]           <= c_valid_in;
                arr_d[c_index]           <= 1'b0;
            end
        end
    end

    // ---------------- environment: main memory, read data 2 cycles after acceptance ----------------
    logic [15:0] mem [32768];
    logic        p1_v, p2_v;
    logic [14:0] p1_a, p2_a;

    always @(posedge clk) begin
        if (m_wr && !m_stall) mem[m_addr[15:1]] <= m_wdata;
        p1_v <= m_rd && !m_stall;
        p1_a <= m_addr[15:1];
        p2_v <= p1_v;
        p2_a <= p1_a;
    end
    assign m_rdata = p2_v ? mem[p2_a] : 16'h0000;

    // accepted memory traffic log
    logic [15:0] rd_log[$];
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];

    always @(negedge clk) begin
        if (m_rd && !m_stall) rd_log.push_back(m_addr);
        if (m_wr && !m_stall) begin
            wr_addr_log.push_back(m_addr);
            wr_data_log.push_back(m_wdata);
        end
    end

    logic any_out;
    assign any_out = |{DataOut, Done, Stall, CacheHit, err, c_en, c_cmp, c_wr, c_index, c_off,
                       c_tag, c_wdata, c_valid_in, m_addr, m_wdata, m_rd, m_wr};

    // ---------------- reference model: coherent word memory + per-line state ----------------
    typedef struct packed {
        logic       v;
        logic       d;
        logic [4:0] t;
    } ref_line_t;

    logic [15:0] gold [32768];
    ref_line_t   rl   [256];
    int          ref_hits, ref_misses;
    int          n_cmp, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // kind: 0 hit, 1 clean miss, 2 dirty miss
    task automatic predict(input logic [15:0] a, input logic wr, input logic [15:0] d,
                           output int kind, output logic [15:0] exp_d);
        int idx;
        idx = int'(a[10:3]);
        if (rl[idx].v && rl[idx].t == a[15:11]) kind = 0;
        else if (rl[idx].v && rl[idx].d)        kind = 2;
        else                                    kind = 1;
        exp_d = gold[a[15:1]];
        if (kind != 0) rl[idx].d = 1'b0;
        rl[idx].v = 1'b1;
        rl[idx].t = a[15:11];
        if (wr) begin
            rl[idx].d      = 1'b1;
            gold[a[15:1]] = d;
        end
    endtask

    // Entered and left just after a rising edge; cycle 0 is the request cycle.
    task automatic access(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          input int sf, input int sl,
                          output int lat, output logic [15:0] dout, output logic hit, output logic s0);
        lat = -1; dout = '0; hit = 1'b0; s0 = 1'b0;
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        for (int cyc = 0; cyc < 100; cyc++) begin
            m_stall = (cyc >= sf) && (cyc < sf + sl);
            @(negedge clk);
            if (cyc == 0) s0 = Stall;
            if (Done) begin
                lat = cyc; dout = DataOut; hit = CacheHit;
            end
            @(posedge clk);
            #1;
            if (lat >= 0) break;
        end
        Rd = 1'b0; Wr = 1'b0; m_stall = 1'b0;
        if (lat < 0) check("timeout_done", 0, 1);
    endtask

    task automatic run_one(input string nm, input logic wr, input logic [15:0] a, input logic [15:0] d,
                           input int sf, input int sl, output int lat);
        int kind, nom;
        logic [15:0] exp_d, dout;
        logic hit, s0;
        predict(a, wr, d, kind, exp_d);
        access(!wr, wr, a, d, sf, sl, lat, dout, hit, s0);
        nom = (kind == 0) ? 0 : (kind == 1) ? 7 : 11;
        check({nm, "_hit"}, hit, (kind == 0));
        check({nm, "_stall0"}, s0, (kind != 0));
        if (sl == 0) check({nm, "_lat"}, lat, nom);
        else         check({nm, "_latmin"}, (lat >= nom), 1);
        if (!wr) check({nm, "_data"}, dout, exp_d);
        if (kind == 0) ref_hits++; else ref_misses++;
    endtask

    task automatic bad_req(input string nm, input logic rd, input logic wr, input logic [15:0] a);
        Rd = rd; Wr = wr; Addr = a; DataIn = 16'h1234;
        @(negedge clk);
        check({nm, "_err"}, err, 1);
        check({nm, "_done"}, Done, 0);
        check({nm, "_cen"}, c_en, 0);
        check({nm, "_mem"}, m_rd | m_wr, 0);
        check({nm, "_stall"}, Stall, 0);
        @(posedge clk);
        #1;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        n_cmp = 0; n_bad = 0; ref_hits = 0; ref_misses = 0;
        for (int i = 0; i < 32768; i++) begin
            mem[i]  = 16'($urandom);
            gold[i] = mem[i];
        end
        for (int i = 0; i < 256; i++) begin
            arr_v[i] = 1'b0; arr_d[i] = 1'b0; arr_t[i] = '0;
            rl[i] = '0;
            for (int j = 0; j < 4; j++) arr_data[i][j] = '0;
        end

        // reset holds every output low even with a request present
        rst = 1'b1; Rd = 1'b1; Wr = 1'b0; Addr = 16'h0010; DataIn = '0; m_stall = 1'b0;
        #12;
        check("reset_outs", any_out, 0);
        Rd = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1;

        // 1: cold read miss, four fill reads in order
        rd_log.delete();
        run_one("t1", 1'b0, 16'h0010, '0, 0, 0, lat);
        check("t1_nrd", rd_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t1_rd_addr", (i < rd_log.size()) ? rd_log[i] : 16'hFFFF, 16'h0010 + 16'(2 * i));

        // 2: same address now hits
        run_one("t2", 1'b0, 16'h0010, '0, 0, 0, lat);

        // 3: store hit, then conflicting read forces write-back of the dirty line
        run_one("t3_st", 1'b1, 16'h0012, 16'hBEEF, 0, 0, lat);
        wr_addr_log.delete(); wr_data_log.delete();
        run_one("t3_ld", 1'b0, 16'h0812, '0, 0, 0, lat);
        check("t3_nwr", wr_addr_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t3_wb_addr", (i < wr_addr_log.size()) ? wr_addr_log[i] : 16'hFFFF, 16'h0010 + 16'(2 * i));
            check("t3_wb_data", (i < wr_data_log.size()) ? wr_data_log[i] : 16'h0000, gold[8 + i]);
        end
        check("t3_mem_beef", mem[9], 16'hBEEF);

        // 4: bank busy for three cycles on fill issue 1
        rd_log.delete();
        run_one("t4", 1'b0, 16'h0030, '0, 2, 3, lat);
        check("t4_lat", lat, 10);
        check("t4_nrd", rd_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t4_rd_addr", (i < rd_log.size()) ? rd_log[i] : 16'hFFFF, 16'h0030 + 16'(2 * i));

        // 5: illegal requests
        bad_req("t5_rdwr", 1'b1, 1'b1, 16'h0010);
        bad_req("t5_odd_rd", 1'b1, 1'b0, 16'h0011);
        bad_req("t5_odd_wr", 1'b0, 1'b1, 16'h0013);
        @(negedge clk);
        check("t5_err_clear", err, 0);
        @(posedge clk); #1;

        // 6: reset during fill issue 2, then a full miss restarts
        Rd = 1'b1; Wr = 1'b0; Addr = 16'h4020; DataIn = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t6_issue2_rd", m_rd, 1);
        check("t6_issue2_addr", m_addr, 16'h4024);
        rst = 1'b1;
        #1;
        check("t6_rst_outs", any_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ref_hits = 0; ref_misses = 0;
        run_one("t6_restart", 1'b0, 16'h4020, '0, 0, 0, lat);

        // random mix over a few conflicting tags, occasional bank stalls
        for (int n = 0; n < 300; n++) begin
            logic [4:0]  t;
            logic [7:0]  ix;
            logic [1:0]  o;
            logic        w;
            int          sf, sl;
            t  = 5'($urandom_range(0, 3));
            ix = 8'($urandom_range(0, 7));
            o  = 2'($urandom_range(0, 3));
            w  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) begin
                sf = $urandom_range(1, 8);
                sl = $urandom_range(1, 3);
            end else begin
                sf = 0;
                sl = 0;
            end
            run_one("rnd", w, {t, ix, o, 1'b0}, 16'($urandom), sf, sl, lat);
        end

`ifdef DCACHE_STATS_EN
        check("stats_hits", hit_cnt, 32'(ref_hits));
        check("stats_misses", miss_cnt, 32'(ref_misses));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
